// File: rtl/effect_delay_if.sv
// effect_delay_if: sample/valid bus between the tremolo stage, the echo stage and the DAC register.
`default_nettype none

interface effect_delay_if;
   logic               i_valid;
   logic               i_enable;
   logic [2:0]         i_level;
   logic signed [15:0] i_data;
   logic signed [15:0] o_data;
   logic               o_valid;

   modport master (output i_valid, output i_enable, output i_level, output i_data,
                   input  o_data,  input  o_valid);
   modport slave  (input  i_valid, input  i_enable, input  i_level, input  i_data,
                   output o_data,  output o_valid);
endinterface

`default_nettype wire

// File: rtl/effect_delay.sv
// effect_delay: echo stage mixing each sample with a delayed copy from a circular buffer.
// Optional decaying feedback into the buffer is enabled by defining EFFECT_DELAY_FEEDBACK_EN.
`default_nettype none

module effect_delay #(
   parameter int ADDR_W    = 12,
   parameter int MIX_SHIFT = 1,
   parameter int FB_SHIFT  = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   effect_delay_if.slave bus
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] c_one   = (ADDR_W + 1)'(1);

`ifdef EFFECT_DELAY_FEEDBACK_EN
   localparam bit c_fb_en = 1'b1;
`else
   localparam bit c_fb_en = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CALC  = 3'd2,
      S_WRITE = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q;
   logic [ADDR_W:0]    fill_q;
   logic [ADDR_W:0]    dlen_q;
   logic signed [15:0] x_q;
   logic               en_q;
   logic signed [15:0] wet_q;
   logic signed [15:0] ram_q;
   logic signed [15:0] o_data_q;
   logic               o_valid_q;
   logic signed [15:0] buf_q [DEPTH];

   logic [ADDR_W-1:0]  w_rd_addr;
   logic [ADDR_W:0]    w_dlen;
   logic signed [15:0] w_wet_mix;
   logic signed [15:0] w_wet_fb;
   logic signed [17:0] w_mix_sum;
   logic signed [17:0] w_fb_sum;
   logic signed [15:0] w_wval;

   function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767)
         return 16'sh7fff;
      else if (v < -18'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   // Level 7 gives dlen = DEPTH, whose low ADDR_W bits are zero, so rd_addr lands on wr_ptr.
   assign w_dlen    = ({{(ADDR_W-2){1'b0}}, bus.i_level} + c_one) << (ADDR_W - 3);
   assign w_rd_addr = wr_ptr_q - dlen_q[ADDR_W-1:0];

   assign w_wet_mix = wet_q >>> MIX_SHIFT;
   assign w_wet_fb  = wet_q >>> FB_SHIFT;
   assign w_mix_sum = {{2{x_q[15]}}, x_q} + {{2{w_wet_mix[15]}}, w_wet_mix};
   assign w_fb_sum  = {{2{x_q[15]}}, x_q} + {{2{w_wet_fb[15]}}, w_wet_fb};
   assign w_wval    = (c_fb_en && en_q) ? sat16(w_fb_sum) : x_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.i_valid) state_d = S_READ;
         S_READ:  state_d = S_CALC;
         S_CALC:  state_d = S_WRITE;
         S_WRITE: state_d = S_OUT;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         fill_q    <= '0;
         dlen_q    <= '0;
         x_q       <= '0;
         en_q      <= 1'b0;
         wet_q     <= '0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         o_valid_q <= (state_q == S_OUT);
         case (state_q)
            S_IDLE: begin
               if (bus.i_valid) begin
                  x_q    <= bus.i_data;
                  en_q   <= bus.i_enable;
                  dlen_q <= w_dlen;
               end
            end
            // Slots not yet written since reset read as silence.
            S_CALC:  wet_q <= (fill_q >= dlen_q) ? ram_q : 16'sd0;
            S_WRITE: begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
               if (fill_q != c_depth) fill_q <= fill_q + c_one;
            end
            S_OUT:   o_data_q <= en_q ? sat16(w_mix_sum) : x_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (state_q == S_READ)  ram_q <= buf_q[w_rd_addr];
      if (state_q == S_WRITE) buf_q[wr_ptr_q] <= w_wval;
   end

   assign bus.o_data  = o_data_q;
   assign bus.o_valid = o_valid_q;

endmodule

`default_nettype wire
